// File: rtl/knn_pkg.sv
// Shared types and ordering helper for the top-K insertion sorter.
// The compare helper works on precomputed lt/eq bits so that callers keep native width.
package knn_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Returns whether a stored value leads (or ties with) a newcomer.
   // On a tie the stored value always leads, which keeps equal keys in arrival order.
   function automatic logic precedes_or_eq(input logic slot_lt, input logic slot_eq,
                                           input logic asc);
      return asc ? (slot_lt | slot_eq) : !slot_lt;
   endfunction

endpackage

// File: rtl/topk_slot.sv
// One retained entry of the sorter: holds data/type/valid, reports whether it leads the
// incoming beat, and either keeps its value, loads the newcomer or shifts from its upper neighbour.
module topk_slot
   import knn_pkg::*;
#(
   parameter int W      = 16,
   parameter int TYPE_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              ins_en,
   input  logic              asc,
   input  logic [W-1:0]      new_data,
   input  logic [TYPE_W-1:0] new_type,
   input  logic [W-1:0]      prev_data,
   input  logic [TYPE_W-1:0] prev_type,
   input  logic              prev_valid,
   input  logic              prev_cmp,
   output logic [W-1:0]      data,
   output logic [TYPE_W-1:0] slot_type,
   output logic              valid,
   output logic              cmp
);

   logic load_new;
   logic shift_in;

   assign cmp      = valid && precedes_or_eq(data < new_data, data == new_data, asc);
   assign load_new = ins_en && !cmp && prev_cmp;
   assign shift_in = ins_en && !cmp && !prev_cmp;

   // NOTE: sequential state is written with non-blocking assignments only, so every slot
   // samples its neighbour's pre-edge value and the whole shift happens in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load_new) begin
         valid <= 1'b1;
      end else if (shift_in) begin
         valid <= prev_valid;
      end
   end

   // NOTE: data/type storage is deliberately left without reset; the valid bit masks it,
   // which keeps the reset net off the wide datapath.
   always_ff @(posedge clk) begin
      if (load_new) begin
         data      <= new_data;
         slot_type <= new_type;
      end else if (shift_in) begin
         data      <= prev_data;
         slot_type <= prev_type;
      end
   end

endmodule

// File: rtl/topk_insertion_sorter.sv
// Streaming top-K selector: keeps the K smallest (or largest) distances of a frame in a
// sorted slot chain, then drains them in order with valid/ready handshaking.
module topk_insertion_sorter
   import knn_pkg::*;
#(
   parameter int K      = 8,
   parameter int W      = 16,
   parameter int TYPE_W = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic                     ascending,
   input  logic [W-1:0]             in_data,
   input  logic [TYPE_W-1:0]        in_type,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [W-1:0]             out_data,
   output logic [TYPE_W-1:0]        out_type,
   output logic                     out_last,
   output logic [$clog2(K+1)-1:0]   out_count
);

   localparam int CNT_W = $clog2(K + 1);
   localparam int IDX_W = $clog2(K);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q;
   logic [IDX_W-1:0]   idx_q;
   logic               asc_q;
   logic               eff_asc;
   logic               accept;
   logic               out_hs;
   logic               drain_done;

   logic [W-1:0]       slot_data [K];
   logic [TYPE_W-1:0]  slot_type [K];
   logic [K-1:0]       slot_valid;
   logic [K-1:0]       slot_cmp;

   assign accept     = in_valid && in_ready;
   assign out_hs     = out_valid && out_ready;
   assign drain_done = out_hs && out_last;
   // The first beat of a frame compares against empty slots, so the live mode is safe there.
   assign eff_asc    = (count_q == '0) ? ascending : asc_q;

   for (genvar gi = 0; gi < K; gi++) begin : g_slot
      if (gi == 0) begin : g_head
         topk_slot #(.W(W), .TYPE_W(TYPE_W)) u_slot (
            .clk(clk), .rst(rst), .clear(drain_done), .ins_en(accept), .asc(eff_asc),
            .new_data(in_data), .new_type(in_type),
            .prev_data('0), .prev_type('0), .prev_valid(1'b0), .prev_cmp(1'b1),
            .data(slot_data[gi]), .slot_type(slot_type[gi]),
            .valid(slot_valid[gi]), .cmp(slot_cmp[gi])
         );
      end else begin : g_body
         topk_slot #(.W(W), .TYPE_W(TYPE_W)) u_slot (
            .clk(clk), .rst(rst), .clear(drain_done), .ins_en(accept), .asc(eff_asc),
            .new_data(in_data), .new_type(in_type),
            .prev_data(slot_data[gi-1]), .prev_type(slot_type[gi-1]),
            .prev_valid(slot_valid[gi-1]), .prev_cmp(slot_cmp[gi-1]),
            .data(slot_data[gi]), .slot_type(slot_type[gi]),
            .valid(slot_valid[gi]), .cmp(slot_cmp[gi])
         );
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_d = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && out_last) state_d = FILL;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         idx_q   <= '0;
         asc_q   <= 1'b1;
      end else begin
         if (drain_done) begin
            count_q <= '0;
            idx_q   <= '0;
         end else begin
            if (accept && count_q != CNT_W'(K)) count_q <= count_q + CNT_W'(1);
            if (out_hs) idx_q <= idx_q + IDX_W'(1);
         end
         if (accept && count_q == '0) asc_q <= ascending;
      end
   end

   // Slots are frozen during drain, so the indexed view is stable under back-pressure.
   assign out_data  = slot_data[idx_q];
   assign out_type  = slot_type[idx_q];
   assign out_last  = (state_q == DRAIN) && (CNT_W'(idx_q) == count_q - CNT_W'(1));
   assign out_count = count_q;

endmodule

// File: tb/tb_topk_insertion_sorter.sv
// Directed bench for topk_insertion_sorter with K=4: ordering, ties, discard, stall and reset.
module tb_topk_insertion_sorter;

   localparam int K      = 4;
   localparam int W      = 16;
   localparam int TYPE_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              in_last;
   logic              ascending;
   logic [W-1:0]      in_data;
   logic [TYPE_W-1:0] in_type;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_data;
   logic [TYPE_W-1:0] out_type;
   logic              out_last;
   logic [2:0]        out_count;

   int tests_run    = 0;
   int tests_failed = 0;

   topk_insertion_sorter #(.K(K), .W(W), .TYPE_W(TYPE_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .ascending(ascending), .in_data(in_data), .in_type(in_type),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_type(out_type), .out_last(out_last),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All tasks start and end just after a falling edge.
   task automatic push(input logic [W-1:0] d, input logic [TYPE_W-1:0] t,
                       input logic last, input logic asc);
      int waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL push_ready: in_ready=%b want 1 (data %0d)", in_ready, d);
      end
      in_valid  = 1'b1;
      in_data   = d;
      in_type   = t;
      in_last   = last;
      ascending = asc;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
   endtask

   task automatic pop(input string name, input logic [W-1:0] ed,
                      input logic [TYPE_W-1:0] et, input logic el);
      int waited = 0;
      while (out_valid !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== ed || out_type !== et || out_last !== el) begin
         tests_failed++;
         $display("FAIL %s: got valid=%b data=%0d type=%0d last=%b, want valid=1 data=%0d type=%0d last=%b",
                  name, out_valid, out_data, out_type, out_last, ed, et, el);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic check_count(input string name, input logic [2:0] ec);
      tests_run++;
      if (out_count !== ec) begin
         tests_failed++;
         $display("FAIL %s: out_count=%0d want %0d", name, out_count, ec);
      end
   endtask

   task automatic check_idle(input string name);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== 3'd0) begin
         tests_failed++;
         $display("FAIL %s: in_ready=%b out_valid=%b out_count=%0d, want 1 0 0",
                  name, in_ready, out_valid, out_count);
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_count !== 3'd0) begin
         tests_failed++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b out_last=%b out_count=%0d, want 1 0 0 0",
                  in_ready, out_valid, out_last, out_count);
      end
   endtask

   task automatic test_ascending();
      push(9, 3'd1, 1'b0, 1'b1);
      push(3, 3'd2, 1'b0, 1'b0);   // mode changes after the first beat must be ignored
      push(7, 3'd3, 1'b0, 1'b0);
      push(1, 3'd4, 1'b0, 1'b1);
      push(5, 3'd5, 1'b1, 1'b0);
      check_count("asc_count", 3'd4);
      pop("asc_0", 1, 3'd4, 1'b0);
      pop("asc_1", 3, 3'd2, 1'b0);
      pop("asc_2", 5, 3'd5, 1'b0);
      pop("asc_3", 7, 3'd3, 1'b1);
      check_idle("asc_return_fill");
   endtask

   task automatic test_descending();
      push(9, 3'd1, 1'b0, 1'b0);
      push(3, 3'd2, 1'b0, 1'b1);
      push(7, 3'd3, 1'b0, 1'b1);
      push(1, 3'd4, 1'b0, 1'b1);
      push(5, 3'd5, 1'b1, 1'b1);
      check_count("desc_count", 3'd4);
      pop("desc_0", 9, 3'd1, 1'b0);
      pop("desc_1", 7, 3'd3, 1'b0);
      pop("desc_2", 5, 3'd5, 1'b0);
      pop("desc_3", 3, 3'd2, 1'b1);
   endtask

   task automatic test_ties();
      push(5, 3'd1, 1'b0, 1'b1);
      push(5, 3'd2, 1'b0, 1'b1);
      push(5, 3'd3, 1'b1, 1'b1);
      check_count("ties_count", 3'd3);
      pop("ties_0", 5, 3'd1, 1'b0);
      pop("ties_1", 5, 3'd2, 1'b0);
      pop("ties_2", 5, 3'd3, 1'b1);
   endtask

   task automatic test_discard();
      // Full block: a tie with the tail and a beat past the tail are both dropped.
      push(1, 3'd1, 1'b0, 1'b1);
      push(2, 3'd2, 1'b0, 1'b1);
      push(3, 3'd3, 1'b0, 1'b1);
      push(4, 3'd4, 1'b0, 1'b1);
      push(4, 3'd6, 1'b0, 1'b1);
      push(9, 3'd7, 1'b1, 1'b1);
      check_count("discard_count", 3'd4);
      pop("discard_0", 1, 3'd1, 1'b0);
      pop("discard_1", 2, 3'd2, 1'b0);
      pop("discard_2", 3, 3'd3, 1'b0);
      pop("discard_3", 4, 3'd4, 1'b1);
   endtask

   task automatic test_partial();
      push(4, 3'd1, 1'b0, 1'b1);
      push(2, 3'd2, 1'b1, 1'b1);
      check_count("partial_count", 3'd2);
      pop("partial_0", 2, 3'd2, 1'b0);
      pop("partial_1", 4, 3'd1, 1'b1);
      check_idle("partial_return_fill");
   endtask

   task automatic test_stall();
      push(2, 3'd2, 1'b0, 1'b1);
      push(1, 3'd1, 1'b0, 1'b1);
      push(3, 3'd3, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         tests_run++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'd1 ||
             out_type !== 3'd1 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold_%0d: valid=%b in_ready=%b data=%0d type=%0d last=%b, want 1 0 1 1 0",
                     c, out_valid, in_ready, out_data, out_type, out_last);
         end
         if (c < 3) @(negedge clk);
      end
      pop("stall_0", 1, 3'd1, 1'b0);
      pop("stall_1", 2, 3'd2, 1'b0);
      pop("stall_2", 3, 3'd3, 1'b1);
   endtask

   task automatic test_reset_mid_drain();
      push(9, 3'd1, 1'b0, 1'b1);
      push(3, 3'd2, 1'b0, 1'b1);
      push(7, 3'd3, 1'b0, 1'b1);
      push(1, 3'd4, 1'b1, 1'b1);
      pop("rstmid_0", 1, 3'd4, 1'b0);
      pop("rstmid_1", 3, 3'd2, 1'b0);
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_async: out_valid=%b out_last=%b, want 0 0", out_valid, out_last);
      end
      check_idle("rstmid_idle");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("rstmid_after_release");
      push(8, 3'd5, 1'b0, 1'b1);
      push(6, 3'd6, 1'b1, 1'b1);
      check_count("rstmid_count", 3'd2);
      pop("rstmid_new_0", 6, 3'd6, 1'b0);
      pop("rstmid_new_1", 8, 3'd5, 1'b1);
      check_idle("rstmid_no_stale");
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      ascending = 1'b1;
      in_data   = '0;
      in_type   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_ascending();
      test_descending();
      test_ties();
      test_discard();
      test_partial();
      test_stall();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
